// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline stall/flush controller.
//               Holds the stall-vector codes, the controller state encoding
//               and a helper that resolves the two lowest-priority hold
//               requests (ID load-use, IF fetch wait).
//               Stall bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Default widths / limits, used as parameter defaults by the controller
   localparam int c_MC_CNT_W = 4;
   localparam int c_MEM_TMO  = 16;

   // Stall codes: a stage register bubbles when its own bit is 1 and the
   // bit of the next stage is 0, so each code holds everything up to and
   // including the requesting stage and bubbles the stage after it.
   localparam logic [5:0] c_STALL_NONE = 6'b000000;
   localparam logic [5:0] c_STALL_IF   = 6'b000011;
   localparam logic [5:0] c_STALL_ID   = 6'b000111;
   localparam logic [5:0] c_STALL_EX   = 6'b001111;
   localparam logic [5:0] c_STALL_MEM  = 6'b011111;

   // Controller states
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_EX_MC    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } pipe_state_e;

   // ID beats IF. An input that is not a clean 1 is treated as "no request",
   // so undefined inputs resolve to no stall.
   function automatic logic [5:0] low_prio_stall(input logic id_req,
                                                 input logic if_req);
      logic [5:0] code;
      code = c_STALL_NONE;
      if (id_req) begin
         code = c_STALL_ID;
      end else if (if_req) begin
         code = c_STALL_IF;
      end
      return code;
   endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Request/response bundle between the pipeline stages and the
//               stall/flush controller.
//               master : pipeline side (drives hold requests, gets stall)
//               slave  : controller side
//   if_req        IF not ready (fetch wait)
//   id_req        ID load-use hazard
//   ex_mc_start   EX begins a multi-cycle op
//   ex_mc_cycles  total EX occupancy N of that op
//   mem_req       MEM has a bus access outstanding
//   mem_ack       bus completes the access this cycle
//   flush_req     mispredict / exception, kill younger stages
//   stall[5:0]    per-stage hold vector
//   flush         one-cycle flush strobe
//   ex_mc_done    final occupancy cycle of a multi-cycle op
//   bus_err       one-cycle MEM wait timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
   parameter int MC_CNT_W = 4
);
   logic                if_req;
   logic                id_req;
   logic                ex_mc_start;
   logic [MC_CNT_W-1:0] ex_mc_cycles;
   logic                mem_req;
   logic                mem_ack;
   logic                flush_req;
   logic [5:0]          stall;
   logic                flush;
   logic                ex_mc_done;
   logic                bus_err;

   modport master (
      output if_req, id_req, ex_mc_start, ex_mc_cycles,
             mem_req, mem_ack, flush_req,
      input  stall, flush, ex_mc_done, bus_err
   );

   modport slave (
      input  if_req, id_req, ex_mc_start, ex_mc_cycles,
             mem_req, mem_ack, flush_req,
      output stall, flush, ex_mc_done, bus_err
   );
endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central stall/flush controller for the 6-stage pipeline
//               (PC, IF, ID, EX, MEM, WB). Merges per-stage hold requests,
//               sequences multi-cycle EX ops and MEM bus waits, and drives
//               the shared stall vector plus a flush strobe.
//               Priority: flush > MEM > EX multi-cycle > ID > IF.
// Ports       :
//   clk   in   single clock, state updates on posedge
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of pipe_ctrl_if (requests in, stall/flush out)
// Parameters  :
//   MC_CNT_W  width of the multi-cycle length field and its counter
//   MEM_TMO   consecutive MEM wait cycles before a bus timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_CNT_W = c_MC_CNT_W,
   parameter int MEM_TMO  = c_MEM_TMO
) (
   input  wire logic   clk,
   input  wire logic   rst,
   pipe_ctrl_if.slave  bus
);

   localparam int                TMO_W      = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
   localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'(MEM_TMO - 1);
   localparam logic [MC_CNT_W-1:0] c_MC_ONE = MC_CNT_W'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   pipe_state_e          r_state;
   pipe_state_e          r_ret_state;   // state to resume once a MEM wait ends
   logic [MC_CNT_W-1:0]  r_mc_cnt;      // EX occupancy cycles still to go
   logic [TMO_W-1:0]     r_tmo_cnt;     // consecutive MEM wait cycles so far

   pipe_state_e          w_state_nxt;
   pipe_state_e          w_ret_nxt;
   pipe_state_e          w_eff_state;
   logic [MC_CNT_W-1:0]  w_mc_cnt_nxt;
   logic [TMO_W-1:0]     w_tmo_nxt;

   logic                 w_mem_wait;
   logic                 w_timeout;
   logic                 w_flush;
   logic [5:0]           w_stall;
   logic                 w_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_ret_state <= ST_RUN;
         r_mc_cnt    <= '0;
         r_tmo_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_state <= w_ret_nxt;
         r_mc_cnt    <= w_mc_cnt_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_ret_nxt    = r_ret_state;
      w_mc_cnt_nxt = r_mc_cnt;
      w_tmo_nxt    = r_tmo_cnt;
      w_stall      = c_STALL_NONE;
      w_done       = 1'b0;

      // An ack without a request is meaningless and simply ignored here.
      w_mem_wait = bus.mem_req & ~bus.mem_ack;
      w_timeout  = w_mem_wait && (r_tmo_cnt == c_TMO_LAST);
      w_flush    = bus.flush_req | w_timeout;

      // MEM_WAIT only wraps the state it interrupted; once the wait is
      // over, that cycle already behaves as the resumed state so no cycle
      // of EX progress is lost on the ack.
      w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

      if (w_flush) begin
         // Kills any in-flight multi-cycle op without a done pulse.
         w_state_nxt  = ST_RUN;
         w_ret_nxt    = ST_RUN;
         w_mc_cnt_nxt = '0;
         w_tmo_nxt    = '0;
      end else if (w_mem_wait) begin
         // EX counter frozen; lower-priority requests are not remembered.
         w_stall     = c_STALL_MEM;
         w_tmo_nxt   = r_tmo_cnt + 1'b1;
         w_state_nxt = ST_MEM_WAIT;
         w_ret_nxt   = w_eff_state;
      end else begin
         w_tmo_nxt   = '0;
         w_state_nxt = w_eff_state;
         case (w_eff_state)
            ST_EX_MC: begin
               if (r_mc_cnt <= c_MC_ONE) begin
                  // Last occupancy cycle: EX releases, ID/IF may hold.
                  w_done       = 1'b1;
                  w_mc_cnt_nxt = '0;
                  w_state_nxt  = ST_RUN;
                  w_stall      = low_prio_stall(bus.id_req, bus.if_req);
               end else begin
                  w_stall      = c_STALL_EX;
                  w_mc_cnt_nxt = r_mc_cnt - 1'b1;
               end
            end
            default: begin
               if (bus.ex_mc_start && (bus.ex_mc_cycles > c_MC_ONE)) begin
                  w_stall      = c_STALL_EX;
                  w_mc_cnt_nxt = bus.ex_mc_cycles - 1'b1;
                  w_state_nxt  = ST_EX_MC;
               end else begin
                  // A single-cycle op completes at once and holds nothing,
                  // so ID/IF requests still apply.
                  if (bus.ex_mc_start) begin
                     w_done = 1'b1;
                  end
                  w_state_nxt = ST_RUN;
                  w_stall     = low_prio_stall(bus.id_req, bus.if_req);
               end
            end
         endcase
      end
   end

   // Outputs are forced quiet while reset is asserted.
   assign bus.stall      = rst ? w_stall : c_STALL_NONE;
   assign bus.flush      = rst & w_flush;
   assign bus.ex_mc_done = rst & w_done;
   assign bus.bus_err    = rst & w_timeout;

endmodule : pipe_ctrl
`default_nettype wire
